// File: rtl/bp_reg_pkg.sv
`default_nettype none
// ============================================================
// bp_reg_pkg: shared BytePipe register-access definitions.
// Revision 1.0
// ============================================================
package bp_reg_pkg;

  localparam int BP_WRITE_BIT = 7;
  localparam int BP_ADDR_W    = 7;
  localparam int BP_DATA_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_CMD  = 3'd1,
    ST_SEND_DATA = 3'd2,
    ST_WAIT_RSP  = 3'd3,
    ST_RSP       = 3'd4
  } bp_reg_state_e;

  function automatic logic [BP_DATA_W-1:0] bp_cmd_byte(input logic write,
                                                       input logic [BP_ADDR_W-1:0] addr);
    logic [BP_DATA_W-1:0] b;
    b               = {1'b0, addr};
    b[BP_WRITE_BIT] = write;
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_reg_initiator_satcnt.sv
`default_nettype none
// ============================================================
// bp_reg_initiator_satcnt: clearable upcounter that sticks at all-ones.
// Revision 1.0
// ============================================================
module bp_reg_initiator_satcnt #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/bp_reg_initiator.sv
`default_nettype none
// ============================================================
// bp_reg_initiator: turns register read/write commands into BytePipe traffic.
// Revision 1.0
// ============================================================
module bp_reg_initiator
  import bp_reg_pkg::*;
#(
  parameter int TIMEOUT_EXP = 8,
  parameter int DROPCOUNT_W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_cg,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic                   i_cmd_write,
  input  logic [BP_ADDR_W-1:0]   i_cmd_addr,
  input  logic [BP_DATA_W-1:0]   i_cmd_wdata,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [BP_DATA_W-1:0]   o_rsp_rdata,
  output logic                   o_rsp_timeout,
  output logic [BP_DATA_W-1:0]   o_bp_data,
  output logic                   o_bp_valid,
  input  logic                   i_bp_ready,
  input  logic [BP_DATA_W-1:0]   i_bp_data,
  input  logic                   i_bp_valid,
  output logic                   o_bp_ready,
  output logic [DROPCOUNT_W-1:0] o_nDropped
);

  // The waiting cycle whose count equals this value is the (2**TIMEOUT_EXP-1)th one.
  localparam logic [TIMEOUT_EXP-1:0] C_TMO_LAST = TIMEOUT_EXP'((2 ** TIMEOUT_EXP) - 2);

  bp_reg_state_e          r_state;
  logic                   r_write;
  logic [BP_DATA_W-1:0]   r_wdata;
  logic                   r_cmd_ready;
  logic                   r_bp_valid;
  logic [BP_DATA_W-1:0]   r_bp_data;
  logic                   r_rsp_valid;
  logic [BP_DATA_W-1:0]   r_rsp_rdata;
  logic                   r_rsp_timeout;

  logic [TIMEOUT_EXP-1:0] w_tmo_count;
  logic                   w_tmo_clr;
  logic                   w_tmo_inc;
  logic                   w_tmo_expire;
  logic                   w_drop_inc;

  assign w_tmo_clr    = i_cg && (r_state == ST_SEND_CMD) && i_bp_ready && !r_write;
  assign w_tmo_inc    = i_cg && (r_state == ST_WAIT_RSP);
  assign w_tmo_expire = (w_tmo_count == C_TMO_LAST);
  assign w_drop_inc   = i_cg && i_bp_valid && (r_state != ST_WAIT_RSP);

  bp_reg_initiator_satcnt #(.W(TIMEOUT_EXP)) u_tmo_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_tmo_clr),
    .i_inc   (w_tmo_inc),
    .o_count (w_tmo_count)
  );

  bp_reg_initiator_satcnt #(.W(DROPCOUNT_W)) u_drop_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (1'b0),
    .i_inc   (w_drop_inc),
    .o_count (o_nDropped)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_write       <= 1'b0;
      r_wdata       <= '0;
      r_cmd_ready   <= 1'b1;
      r_bp_valid    <= 1'b0;
      r_bp_data     <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
    end else if (i_cg) begin
      case (r_state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            r_write     <= i_cmd_write;
            r_wdata     <= i_cmd_wdata;
            r_cmd_ready <= 1'b0;
            r_bp_valid  <= 1'b1;
            r_bp_data   <= bp_cmd_byte(i_cmd_write, i_cmd_addr);
            r_state     <= ST_SEND_CMD;
          end
        end
        ST_SEND_CMD: begin
          if (i_bp_ready) begin
            if (r_write) begin
              r_bp_data <= r_wdata;
              r_state   <= ST_SEND_DATA;
            end else begin
              r_bp_valid <= 1'b0;
              r_bp_data  <= '0;
              r_state    <= ST_WAIT_RSP;
            end
          end
        end
        ST_SEND_DATA: begin
          if (i_bp_ready) begin
            r_bp_valid    <= 1'b0;
            r_bp_data     <= '0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b0;
            r_state       <= ST_RSP;
          end
        end
        ST_WAIT_RSP: begin
          // A byte landing on the expiry cycle takes priority over the timeout.
          if (i_bp_valid) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= i_bp_data;
            r_rsp_timeout <= 1'b0;
            r_state       <= ST_RSP;
          end else if (w_tmo_expire) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b1;
            r_state       <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (i_rsp_ready) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready   = r_cmd_ready;
  assign o_bp_valid    = r_bp_valid;
  assign o_bp_data     = r_bp_data;
  assign o_bp_ready    = 1'b1;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_bp_reg_initiator.sv
`default_nettype none
// ============================================================
// tb_bp_reg_initiator: directed and random checks against a transaction model.
// Revision 1.0
// ============================================================
module tb_bp_reg_initiator;

  localparam int TEXP       = 4;
  localparam int DW         = 8;
  localparam int WAIT_LIMIT = (1 << TEXP) - 1;
  localparam int DROP_MAX   = (1 << DW) - 1;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_cg;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_cmd_write;
  logic [6:0]    i_cmd_addr;
  logic [7:0]    i_cmd_wdata;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [7:0]    o_rsp_rdata;
  logic          o_rsp_timeout;
  logic [7:0]    o_bp_data;
  logic          o_bp_valid;
  logic          i_bp_ready;
  logic [7:0]    i_bp_data;
  logic          i_bp_valid;
  logic          o_bp_ready;
  logic [DW-1:0] o_nDropped;

  int n_checks = 0;
  int n_errors = 0;

  bp_reg_initiator #(.TIMEOUT_EXP(TEXP), .DROPCOUNT_W(DW)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_cg          (i_cg),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_write   (i_cmd_write),
    .i_cmd_addr    (i_cmd_addr),
    .i_cmd_wdata   (i_cmd_wdata),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_rdata   (o_rsp_rdata),
    .o_rsp_timeout (o_rsp_timeout),
    .o_bp_data     (o_bp_data),
    .o_bp_valid    (o_bp_valid),
    .i_bp_ready    (i_bp_ready),
    .i_bp_data     (i_bp_data),
    .i_bp_valid    (i_bp_valid),
    .o_bp_ready    (o_bp_ready),
    .o_nDropped    (o_nDropped)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Transaction-level model: bytes still to transmit, waiting-cycle tally, pending response.
  bit         m_busy    = 0;
  bit         m_write   = 0;
  bit         m_waiting = 0;
  bit         m_rsp     = 0;
  int         m_wait_n  = 0;
  logic [7:0] m_rdata   = 8'h00;
  bit         m_tmo     = 0;
  int         m_drop    = 0;
  logic [7:0] m_txq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit was_waiting;
    if (!i_rst_n) begin
      m_busy = 0; m_write = 0; m_waiting = 0; m_rsp = 0;
      m_wait_n = 0; m_rdata = 8'h00; m_tmo = 0; m_drop = 0;
      m_txq.delete();
    end else if (i_cg) begin
      was_waiting = m_waiting;
      if (i_bp_valid && !was_waiting && m_drop < DROP_MAX) m_drop++;
      if (!m_busy) begin
        if (i_cmd_valid) begin
          m_busy  = 1;
          m_write = i_cmd_write;
          m_txq.delete();
          m_txq.push_back({i_cmd_write, i_cmd_addr});
          if (i_cmd_write) m_txq.push_back(i_cmd_wdata);
        end
      end else if (m_txq.size() > 0) begin
        if (i_bp_ready) begin
          void'(m_txq.pop_front());
          if (m_txq.size() == 0) begin
            if (m_write) begin
              m_rsp = 1; m_rdata = 8'h00; m_tmo = 0;
            end else begin
              m_waiting = 1; m_wait_n = 0;
            end
          end
        end
      end else if (m_waiting) begin
        if (i_bp_valid) begin
          m_waiting = 0; m_rsp = 1; m_rdata = i_bp_data; m_tmo = 0;
        end else begin
          m_wait_n++;
          if (m_wait_n == WAIT_LIMIT) begin
            m_waiting = 0; m_rsp = 1; m_rdata = 8'h00; m_tmo = 1;
          end
        end
      end else if (m_rsp && i_rsp_ready) begin
        m_rsp  = 0;
        m_busy = 0;
      end
    end
  endtask

  task automatic compare();
    chk("cmd_ready", {31'b0, o_cmd_ready}, {31'b0, !m_busy});
    chk("bp_valid", {31'b0, o_bp_valid}, {31'b0, m_txq.size() > 0});
    chk("bp_ready", {31'b0, o_bp_ready}, 32'd1);
    chk("rsp_valid", {31'b0, o_rsp_valid}, {31'b0, m_rsp});
    chk("nDropped", {24'b0, o_nDropped}, m_drop);
    if (m_txq.size() > 0) chk("bp_data", {24'b0, o_bp_data}, {24'b0, m_txq[0]});
    if (m_rsp) begin
      chk("rsp_rdata", {24'b0, o_rsp_rdata}, {24'b0, m_rdata});
      chk("rsp_timeout", {31'b0, o_rsp_timeout}, {31'b0, m_tmo});
    end
  endtask

  initial begin
    forever begin
      @(negedge i_clk);
      model_step();
      compare();
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [6:0] addr, input logic [7:0] wd);
    i_cmd_valid = 1; i_cmd_write = wr; i_cmd_addr = addr; i_cmd_wdata = wd;
    tick();
    i_cmd_valid = 0;
  endtask

  task automatic wait_rsp(input string name);
    int n;
    n = 0;
    while (!o_rsp_valid && n < 100) begin
      tick();
      n++;
    end
    chk(name, {31'b0, o_rsp_valid}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, {31'b0, o_cmd_ready}, 32'd1);
    chk({tag, "_bp_valid"}, {31'b0, o_bp_valid}, 32'd0);
    chk({tag, "_bp_data"}, {24'b0, o_bp_data}, 32'd0);
    chk({tag, "_bp_ready"}, {31'b0, o_bp_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'b0, o_rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, {24'b0, o_rsp_rdata}, 32'd0);
    chk({tag, "_rsp_timeout"}, {31'b0, o_rsp_timeout}, 32'd0);
    chk({tag, "_nDropped"}, {24'b0, o_nDropped}, 32'd0);
  endtask

  initial begin
    int n;
    i_rst_n = 0; i_cg = 1; i_cmd_valid = 0; i_cmd_write = 0; i_cmd_addr = '0;
    i_cmd_wdata = '0; i_rsp_ready = 0; i_bp_ready = 0; i_bp_data = '0; i_bp_valid = 0;
    tick(); tick();
    chk_reset_vals("reset");
    i_rst_n = 1;
    tick();

    // Write 0x05 <- 0xA3 with ready peers.
    i_bp_ready = 1; i_rsp_ready = 1;
    send_cmd(1'b1, 7'h05, 8'hA3);
    chk("wr_cmd_byte", {24'b0, o_bp_data}, 32'h85);
    chk("wr_cmd_valid", {31'b0, o_bp_valid}, 32'd1);
    tick();
    chk("wr_data_byte", {24'b0, o_bp_data}, 32'hA3);
    chk("wr_rsp_early", {31'b0, o_rsp_valid}, 32'd0);
    tick();
    chk("wr_rsp_valid", {31'b0, o_rsp_valid}, 32'd1);
    chk("wr_rsp_rdata", {24'b0, o_rsp_rdata}, 32'h00);
    chk("wr_rsp_tmo", {31'b0, o_rsp_timeout}, 32'd0);
    tick();
    chk("wr_back_idle", {31'b0, o_cmd_ready}, 32'd1);

    // Read 0x12, reply 0x5C ten cycles after accept.
    i_rsp_ready = 0;
    send_cmd(1'b0, 7'h12, 8'h00);
    chk("rd_cmd_byte", {24'b0, o_bp_data}, 32'h12);
    repeat (9) tick();
    i_bp_valid = 1; i_bp_data = 8'h5C;
    tick();
    i_bp_valid = 0;
    wait_rsp("rd_rsp_seen");
    chk("rd_rsp_rdata", {24'b0, o_rsp_rdata}, 32'h5C);
    chk("rd_rsp_tmo", {31'b0, o_rsp_timeout}, 32'd0);
    i_rsp_ready = 1;
    tick();
    i_rsp_ready = 0;

    // Read with no reply: timeout 15 enabled cycles after entering the wait.
    send_cmd(1'b0, 7'h33, 8'h00);
    tick();
    n = 0;
    while (!o_rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk("tmo_latency", n, 32'd15);
    chk("tmo_flag", {31'b0, o_rsp_timeout}, 32'd1);
    chk("tmo_rdata", {24'b0, o_rsp_rdata}, 32'h00);
    i_bp_valid = 1; i_bp_data = 8'h77;
    tick();
    i_bp_valid = 0;
    chk("late_byte_dropped", {24'b0, o_nDropped}, 32'd1);
    i_rsp_ready = 1;
    tick();
    i_rsp_ready = 0;

    // Byte on the expiry cycle wins over the timeout.
    send_cmd(1'b0, 7'h44, 8'h00);
    tick();
    repeat (14) tick();
    chk("expiry_not_yet", {31'b0, o_rsp_valid}, 32'd0);
    i_bp_valid = 1; i_bp_data = 8'hC9;
    tick();
    i_bp_valid = 0;
    chk("expiry_rsp", {31'b0, o_rsp_valid}, 32'd1);
    chk("expiry_rdata", {24'b0, o_rsp_rdata}, 32'hC9);
    chk("expiry_tmo", {31'b0, o_rsp_timeout}, 32'd0);
    chk("expiry_no_drop", {24'b0, o_nDropped}, 32'd1);
    i_rsp_ready = 1;
    tick();

    // Back-pressure during SEND_CMD with clock gating toggling.
    i_bp_ready = 0;
    send_cmd(1'b0, 7'h2A, 8'h00);
    for (int i = 0; i < 5; i++) begin
      i_cg = i[0];
      tick();
      chk("bp_hold_valid", {31'b0, o_bp_valid}, 32'd1);
      chk("bp_hold_data", {24'b0, o_bp_data}, 32'h2A);
    end
    i_cg = 1; i_bp_ready = 1;
    tick();
    i_bp_valid = 1; i_bp_data = 8'h3C;
    tick();
    i_bp_valid = 0;
    chk("bp_hold_rsp", {24'b0, o_rsp_rdata}, 32'h3C);
    tick();

    // Reset pulse while waiting for the reply.
    send_cmd(1'b0, 7'h01, 8'h00);
    tick(); tick();
    i_rst_n = 0;
    #1;
    chk_reset_vals("midrst");
    tick();
    i_rst_n = 1;
    repeat (10) tick();
    chk("midrst_no_rsp", {31'b0, o_rsp_valid}, 32'd0);
    i_bp_valid = 1; i_bp_data = 8'h11;
    tick();
    i_bp_valid = 0;
    chk("midrst_drop", {24'b0, o_nDropped}, 32'd1);

    // 300 unsolicited bytes in IDLE saturate the drop counter.
    i_rst_n = 0;
    tick();
    i_rst_n = 1;
    i_bp_valid = 1;
    repeat (300) begin
      i_bp_data = 8'($urandom);
      tick();
    end
    i_bp_valid = 0;
    chk("drop_saturate", {24'b0, o_nDropped}, 32'd255);
    chk("model_drop_saturate", m_drop, 32'd255);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        i_rst_n = 0;
        tick();
        i_rst_n = 1;
      end
      i_cg        = ($urandom_range(0, 99) < 85);
      i_cmd_valid = ($urandom_range(0, 1) == 1);
      i_cmd_write = ($urandom_range(0, 1) == 1);
      i_cmd_addr  = 7'($urandom);
      i_cmd_wdata = 8'($urandom);
      i_bp_ready  = ($urandom_range(0, 99) < 70);
      i_bp_valid  = ($urandom_range(0, 99) < 8);
      i_bp_data   = 8'($urandom);
      i_rsp_ready = ($urandom_range(0, 99) < 60);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
